dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: data-memory address width.
REQ-002 Parameter DATA_W, default 16: data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, legal range 1..15: number of consecutive lost cycles before the host forces a core stall.
REQ-004 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port core_rd_en, input, 1: core load (LW) in EX this cycle.
REQ-007 Port core_wr_en, input, 1: core store (SW) in EX this cycle.
REQ-008 Port core_addr / core_wdata, input, ADDR_W / DATA_W: core access address and store data.
REQ-009 Port core_rdata, output, DATA_W: load data, equal to mem_rdata.
REQ-010 Port core_stall, output, 1: freezes the core pipeline for one cycle.
REQ-011 Port host_req / host_we, input, 1 / 1: host access request; write when host_we=1, read when host_we=0.
REQ-012 Port host_addr / host_wdata, input, ADDR_W / DATA_W: host access address and write data.
REQ-013 Port host_gnt, output, 1: one-cycle pulse; the host access is issued to memory this cycle.
REQ-014 Port host_rdata / host_rvalid, output, DATA_W / 1: host read data and its qualifier.
REQ-015 Port mem_en / mem_we, output, 1 / 1: memory enable and write strobe.
REQ-016 Port mem_addr / mem_wdata, output, ADDR_W / DATA_W: memory address and write data.
REQ-017 Port mem_rdata, input, DATA_W: synchronous-read data, valid one cycle after the read is issued.

Function
REQ-018 core_access SHALL be defined as core_rd_en|core_wr_en; asserting both rd_en and wr_en together SHALL be treated as a write.
REQ-019 States SHALL be S_IDLE, S_WAIT and S_STALL.
REQ-020 The core SHALL have priority: when core_access=1 and the state is not S_STALL, the mem_* outputs SHALL carry the core access in the same cycle (zero added latency).
REQ-021 In S_IDLE or S_WAIT with host_req=1 and core_access=0, host_gnt SHALL be 1, mem_* SHALL carry the host access, the next state SHALL be S_IDLE and the counter SHALL clear.
REQ-022 In S_IDLE with host_req=1 and core_access=1, the next state SHALL be S_WAIT and the counter SHALL load 1.
REQ-023 In S_WAIT with host_req=1 and core_access=1, the counter SHALL increment; when the counter equals STARVE_LIMIT, the next state SHALL be S_STALL.
REQ-024 In S_STALL, core_stall=1, host_gnt=1, mem_* SHALL carry the host access, the core access SHALL be suppressed, and the next state SHALL be S_IDLE with the counter cleared.
REQ-025 The host SHALL hold host_req and all host_* inputs stable until host_gnt; dropping host_req in S_WAIT SHALL return the state to S_IDLE and clear the counter.
REQ-026 host_rvalid SHALL be a registered flag equal to 1 in the cycle after a granted read (host_gnt=1 and host_we=0), and 0 otherwise; host_rdata SHALL equal mem_rdata.
REQ-027 A core load issued in the cycle before S_STALL SHALL still receive correct core_rdata during the S_STALL cycle.
REQ-028 With no core access and no host grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata are don't-care but SHALL NOT be X.
REQ-029 The counter width SHALL be 4 bits, and the counter SHALL saturate, never wrapping.

Reset
REQ-030 Asserting rst_n low SHALL at any time force S_IDLE, clear the counter, and drive host_rvalid=0, core_stall=0, host_gnt=0, mem_en=0 and mem_we=0.
REQ-031 A host request pending at reset SHALL be discarded and SHALL be re-arbitrated from S_IDLE after reset release.

Structure
REQ-032 A shared package dmem_arb_pkg SHALL hold the state encodings and the default values of ADDR_W, DATA_W and STARVE_LIMIT.
REQ-033 The starvation counter SHALL be a sub-module, arb_starve_cnt, with inputs clr, inc and limit, and output hit.
REQ-034 All outputs except host_rvalid SHALL be combinational from the state and the inputs.

Verification
REQ-035 Host read with the core idle, addr 0x0010, mem holding 0xBEEF -> host_gnt in cycle 0, then host_rvalid=1 with host_rdata=0xBEEF in cycle 1.
REQ-036 Core SW 0x1234 to 0x0004 concurrent with a host request -> memory holds 0x1234 at 0x0004, host_gnt=0, state S_WAIT.
REQ-037 Core busy for 10 cycles, host write pending, STARVE_LIMIT=4 -> core_stall=1 and host_gnt=1 in the 5th cycle of the request, and exactly one stall cycle.
REQ-038 Host request dropped in S_WAIT after 2 cycles -> returns to S_IDLE, counter 0, no grant.
REQ-039 rst_n low in S_WAIT with count 3 -> immediate S_IDLE, all outputs at reset values, no stall after release.
REQ-040 Core load in the cycle before S_STALL -> core_rdata is correct in the stall cycle and host_rvalid is asserted one cycle after the grant.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 16;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the host has lost to the core.
// hit flags that the count after this cycle's increment reaches limit.
module arb_starve_cnt
    import dmem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // clr together with inc loads 1: first lost cycle of a fresh request
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = inc ? CNT_W'(1) : '0;
        end else if (inc && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign hit = inc && !clr && (w_cnt_nxt >= limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core has zero-latency priority, the host
// wins when the core is idle or after STARVE_LIMIT lost cycles via a one-cycle core stall.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_rd_en,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_host_rvalid;
    logic       w_core_acc;
    logic       w_clr;
    logic       w_inc;
    logic       w_hit;

    assign w_core_acc  = core_rd_en | core_wr_en;
    assign core_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign host_rvalid = r_host_rvalid;

    // Counter control kept apart from next-state logic, which consumes hit
    always_comb begin
        w_clr = 1'b1;
        w_inc = 1'b0;
        if ((r_state != S_STALL) && w_core_acc && host_req) begin
            w_clr = (r_state == S_IDLE);
            w_inc = 1'b1;
        end
    end

    arb_starve_cnt u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_inc),
        .limit (CNT_W'(STARVE_LIMIT)),
        .hit   (w_hit)
    );

    always_comb begin
        core_stall  = 1'b0;
        host_gnt    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_state_nxt = S_IDLE;
        if (r_state == S_STALL) begin
            core_stall = 1'b1;
            host_gnt   = 1'b1;
            mem_en     = 1'b1;
            mem_we     = host_we;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
        end else if (w_core_acc) begin
            mem_en    = 1'b1;
            mem_we    = core_wr_en;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            if (host_req) begin
                if (r_state == S_IDLE) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = w_hit ? S_STALL : S_WAIT;
                end
            end
        end else if (host_req) begin
            host_gnt  = 1'b1;
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
        // Reset must silence the memory and handshakes immediately, not at the next edge
        if (!rst_n) begin
            core_stall = 1'b0;
            host_gnt   = 1'b0;
            mem_en     = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_host_rvalid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_host_rvalid <= host_gnt & ~host_we;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run scored against a lost-cycle-count model and a shadow memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LIM = 4;

    logic          clk;
    logic          rst_n;
    logic          core_rd_en, core_wr_en;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          host_gnt, host_rvalid;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_rd_en(core_rd_en), .core_wr_en(core_wr_en),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory behind the arbiter
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic hr, input logic hw,
                         input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(negedge clk);
        core_rd_en = rd; core_wr_en = wr; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        core_rd_en = 1'b1; core_wr_en = 1'b0; core_addr = 16'h0004; core_wdata = '0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 16'h1111;
        #1;
        checks++; if (host_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", host_gnt); end
        checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", core_stall); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (host_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", host_rvalid); end
        @(negedge clk);
        core_rd_en = 1'b0; host_req = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL idle_mem_en got=%b exp=0", mem_en); end
        checks++; if ($isunknown(mem_addr) || $isunknown(mem_wdata)) begin failures++; $display("FAIL idle_mem_x got=%h/%h exp=known", mem_addr, mem_wdata); end
    endtask

    task automatic test_host_read();
        drive(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, '0, '0);
        checks++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 16'h0010}) begin failures++; $display("FAIL core_sw got=%b%b %h exp=11 0010", mem_en, mem_we, mem_addr); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0010, '0);
        checks++; if (host_gnt !== 1'b1) begin failures++; $display("FAIL hrd_gnt got=%b exp=1", host_gnt); end
        checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0010}) begin failures++; $display("FAIL hrd_mem got=%b%b %h exp=10 0010", mem_en, mem_we, mem_addr); end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checks++; if (host_rvalid !== 1'b1) begin failures++; $display("FAIL hrd_rvalid got=%b exp=1", host_rvalid); end
        checks++; if (host_rdata !== 16'hBEEF) begin failures++; $display("FAIL hrd_rdata got=%h exp=beef", host_rdata); end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checks++; if (host_rvalid !== 1'b0) begin failures++; $display("FAIL hrd_rvalid_drop got=%b exp=0", host_rvalid); end
    endtask

    task automatic test_core_priority();
        drive(1'b0, 1'b1, 16'h0004, 16'h1234, 1'b1, 1'b1, 16'h0020, 16'h5555);
        checks++; if (host_gnt !== 1'b0) begin failures++; $display("FAIL prio_gnt got=%b exp=0", host_gnt); end
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0004, 16'h1234}) begin failures++; $display("FAIL prio_mem got=%b %h %h exp=1 0004 1234", mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        checks++; if (dut.r_state !== S_WAIT) begin failures++; $display("FAIL prio_state got=%0d exp=%0d", dut.r_state, S_WAIT); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0020, 16'h5555);
        checks++; if ({host_gnt, mem_we, mem_addr} !== {2'b11, 16'h0020}) begin failures++; $display("FAIL prio_hwr got=%b%b %h exp=11 0020", host_gnt, mem_we, mem_addr); end
        drive(1'b1, 1'b0, 16'h0004, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checks++; if (core_rdata !== 16'h1234) begin failures++; $display("FAIL prio_mem_hold got=%h exp=1234", core_rdata); end
    endtask

    task automatic test_starve();
        int stalls = 0;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b0, 16'h0004, '0, (k <= 5), 1'b1, 16'h0030, 16'hA5A5);
            if (core_stall) stalls++;
            checks++; if (core_stall !== (k == 5)) begin failures++; $display("FAIL starve_stall c%0d got=%b exp=%b", k, core_stall, (k == 5)); end
            checks++; if (host_gnt !== (k == 5)) begin failures++; $display("FAIL starve_gnt c%0d got=%b exp=%b", k, host_gnt, (k == 5)); end
            if (k == 5) begin
                checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0030, 16'hA5A5}) begin failures++; $display("FAIL starve_mem got=%b %h %h exp=1 0030 a5a5", mem_we, mem_addr, mem_wdata); end
            end
        end
        checks++; if (stalls != 1) begin failures++; $display("FAIL starve_count got=%0d exp=1", stalls); end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_drop();
        drive(1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0010, '0);
        drive(1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0010, '0);
        drive(1'b1, 1'b0, 16'h0004, '0, 1'b0, 1'b0, 16'h0010, '0);
        checks++; if (host_gnt !== 1'b0) begin failures++; $display("FAIL drop_gnt got=%b exp=0", host_gnt); end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checks++; if (dut.r_state !== S_IDLE) begin failures++; $display("FAIL drop_state got=%0d exp=%0d", dut.r_state, S_IDLE); end
        // A fresh request must again lose exactly LIM cycles, proving the count restarted
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 16'h0004, '0, (k <= 5), 1'b0, 16'h0010, '0);
            checks++; if (host_gnt !== (k == 5)) begin failures++; $display("FAIL drop_regnt c%0d got=%b exp=%b", k, host_gnt, (k == 5)); end
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_in_wait();
        for (int k = 1; k <= 3; k++) drive(1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b1, 16'h0040, 16'h0BAD);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (dut.r_state !== S_IDLE) begin failures++; $display("FAIL rstw_state got=%0d exp=%0d", dut.r_state, S_IDLE); end
        checks++; if ({host_gnt, core_stall, mem_en, mem_we, host_rvalid} !== 5'b0) begin failures++; $display("FAIL rstw_outs got=%b exp=00000", {host_gnt, core_stall, mem_en, mem_we, host_rvalid}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            host_req = (k <= 5);
            #1;
            checks++; if (core_stall !== (k == 5)) begin failures++; $display("FAIL rstw_stall c%0d got=%b exp=%b", k, core_stall, (k == 5)); end
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_load_before_stall();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b0, (k >= 4) ? 16'h0020 : 16'h0004, '0, 1'b1, 1'b0, 16'h0030, '0);
        end
        checks++; if ({core_stall, host_gnt, mem_we} !== 3'b110) begin failures++; $display("FAIL lbs_stall got=%b exp=110", {core_stall, host_gnt, mem_we}); end
        checks++; if (core_rdata !== 16'h5555) begin failures++; $display("FAIL lbs_core_rdata got=%h exp=5555", core_rdata); end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checks++; if (host_rvalid !== 1'b1) begin failures++; $display("FAIL lbs_rvalid got=%b exp=1", host_rvalid); end
        checks++; if (host_rdata !== 16'hA5A5) begin failures++; $display("FAIL lbs_rdata got=%h exp=a5a5", host_rdata); end
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [0:15];
        logic          hr = 1'b0, hw = 1'b0;
        logic [AW-1:0] ha = '0;
        logic [DW-1:0] hd = '0;
        logic          rd, wr, acc, stall_e, gnt_e, we_e;
        logic [AW-1:0] ca, addr_e;
        logic [DW-1:0] cd, wd_e;
        logic [1:0]    sel;
        logic          exp_rv = 1'b0, core_pend = 1'b0;
        logic [DW-1:0] exp_hrd = '0, exp_crd = '0;
        int            waited = 0;
        for (int i = 0; i < 16; i++) begin
            cd = 16'($urandom);
            ref_mem[i] = cd;
            drive(1'b0, 1'b1, 16'h0080 + 16'(i), cd, 1'b0, 1'b0, '0, '0);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        for (int n = 0; n < 400; n++) begin
            if (!hr && ($urandom_range(0, 1) == 1)) begin
                hr = 1'b1;
                hw = 1'($urandom_range(0, 1));
                ha = 16'h0080 + 16'($urandom_range(0, 15));
                hd = 16'($urandom);
            end
            acc = ($urandom_range(0, 9) < 6);
            sel = 2'($urandom_range(1, 3));
            rd  = acc & sel[0];
            wr  = acc & sel[1];
            ca  = 16'h0080 + 16'($urandom_range(0, 15));
            cd  = 16'($urandom);
            drive(rd, wr, ca, cd, hr, hw, ha, hd);

            checks++; if (host_rvalid !== exp_rv) begin failures++; $display("FAIL rnd_rvalid n%0d got=%b exp=%b", n, host_rvalid, exp_rv); end
            if (exp_rv) begin
                checks++; if (host_rdata !== exp_hrd) begin failures++; $display("FAIL rnd_hrdata n%0d got=%h exp=%h", n, host_rdata, exp_hrd); end
            end
            if (core_pend) begin
                checks++; if (core_rdata !== exp_crd) begin failures++; $display("FAIL rnd_crdata n%0d got=%h exp=%h", n, core_rdata, exp_crd); end
            end

            stall_e = hr && (waited >= LIM);
            gnt_e   = stall_e || (hr && !acc);
            we_e    = gnt_e ? hw : wr;
            addr_e  = gnt_e ? ha : ca;
            wd_e    = gnt_e ? hd : cd;
            checks++; if ({core_stall, host_gnt, mem_en} !== {stall_e, gnt_e, gnt_e | acc}) begin failures++; $display("FAIL rnd_ctrl n%0d got=%b exp=%b", n, {core_stall, host_gnt, mem_en}, {stall_e, gnt_e, gnt_e | acc}); end
            if (gnt_e || acc) begin
                checks++; if ({mem_we, mem_addr} !== {we_e, addr_e}) begin failures++; $display("FAIL rnd_mem n%0d got=%b %h exp=%b %h", n, mem_we, mem_addr, we_e, addr_e); end
                if (we_e) begin
                    checks++; if (mem_wdata !== wd_e) begin failures++; $display("FAIL rnd_wdata n%0d got=%h exp=%h", n, mem_wdata, wd_e); end
                end
            end

            exp_rv    = gnt_e && !hw;
            core_pend = !gnt_e && acc && !wr;
            if (gnt_e || acc) begin
                if (we_e) ref_mem[addr_e[3:0]] = wd_e;
                else if (gnt_e) exp_hrd = ref_mem[addr_e[3:0]];
                else exp_crd = ref_mem[addr_e[3:0]];
            end
            waited = (gnt_e || !hr) ? 0 : waited + 1;
            if (gnt_e) hr = 1'b0;
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_host_read();
        test_core_priority();
        test_starve();
        test_drop();
        test_reset_in_wait();
        test_load_before_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
